matrix_scan_decoder: RTL and testbench

- Receive end of the 4x4 row-scanned LED matrix interface driven by the clock display.
- Samples the active-low one-hot row pins and the column pins, rebuilds the 16-pixel frame and checks the scan sequence.
- Decodes hours/minutes from the frame and reports frame-valid, lock and error status.
- Used as an on-chip loopback checker, or in a companion chip that captures a displayed time.

---
 rtl/matrix_scan_decoder.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_matrix_scan_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_decoder.sv
// ---------------------------------------------------------------------------
// matrix_scan_decoder
//
// Receive side of the 4x4 row-scanned LED matrix link driven by the clock
// display. Every rising clk edge samples the active-low one-hot row pins and
// the column pins. The block rebuilds the 16-pixel frame row by row, checks
// that the scan order and hold times are legal, and then checks the frame
// contents. It decodes hours/minutes from the last accepted frame and
// reports frame-valid, lock and error status.
//
// Parameters:
//   HOLD_MAX    - max consecutive samples a row may be held (1..15)
//   LOCK_FRAMES - consecutive good frames needed for locked (1..15)
//
// Ports:
//   clk         - sampling clock
//   rst         - asynchronous, active-high reset
//   scan_rows   - row drive, active-low one-hot (1110=row0 .. 0111=row3),
//                 0000 = blank, any other pattern is invalid
//   scan_cols   - column pixels of the active row, bit n = pixel[4*row+n]
//   pixels      - last accepted frame
//   hours       - pixels[10:6] of the last accepted frame
//   minutes     - pixels[5:0] of the last accepted frame
//   frame_valid - one-cycle pulse when a frame is accepted
//   locked      - LOCK_FRAMES consecutive good frames since last error/blank
//   err_cnt     - saturating error-event counter
//
// Build option:
//   MATRIX_SCAN_SYNC_EN - when defined, scan_rows/scan_cols pass through a
//   2-flop synchronizer before classification (all latencies grow by 2
//   cycles); when undefined the pins are sampled directly and must be
//   synchronous to clk.
// ---------------------------------------------------------------------------
module matrix_scan_decoder #(
  parameter int HOLD_MAX    = 4,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  scan_rows,
  input  logic [3:0]  scan_cols,
  output logic [15:0] pixels,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic        frame_valid,
  output logic        locked,
  output logic [7:0]  err_cnt
);

  localparam logic [4:0] HOLD_LIM = 5'(HOLD_MAX);
  localparam logic [3:0] LOCK_LIM = 4'(LOCK_FRAMES);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Input capture
  // -------------------------------------------------------------------------
  logic [3:0] rows_s;
  logic [3:0] cols_s;

`ifdef MATRIX_SCAN_SYNC_EN
  logic [3:0] rows_meta_reg;
  logic [3:0] rows_sync_reg;
  logic [3:0] cols_meta_reg;
  logic [3:0] cols_sync_reg;

  // Reset value 0000 reads as a blank row, which is harmless in HUNT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_meta_reg <= 4'b0000;
      rows_sync_reg <= 4'b0000;
      cols_meta_reg <= 4'b0000;
      cols_sync_reg <= 4'b0000;
    end else begin
      rows_meta_reg <= scan_rows;
      rows_sync_reg <= rows_meta_reg;
      cols_meta_reg <= scan_cols;
      cols_sync_reg <= cols_meta_reg;
    end
  end

  assign rows_s = rows_sync_reg;
  assign cols_s = cols_sync_reg;
`else
  assign rows_s = scan_rows;
  assign cols_s = scan_cols;
`endif

  // -------------------------------------------------------------------------
  // Row classification
  // -------------------------------------------------------------------------
  logic [3:0] row_hit;
  logic [1:0] row_idx;
  logic       row_valid;
  logic       row_blank;
  logic       row_invalid;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row_hit
      // Active-low one-hot: row gi drives only bit gi low.
      localparam logic [3:0] ROW_PAT = 4'hF ^ (4'h1 << gi);
      assign row_hit[gi] = (rows_s == ROW_PAT);
    end
  endgenerate

  always_comb begin
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_hit[i]) begin
        row_idx = 2'(i);
      end
    end
  end

  assign row_valid   = |row_hit;
  assign row_blank   = (rows_s == 4'b0000);
  assign row_invalid = !row_valid && !row_blank;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t      state_reg,       state_next;
  logic [1:0]  prev_reg,        prev_next;
  logic [3:0]  hold_reg,        hold_next;
  logic [15:0] partial_reg,     partial_next;
  logic [3:0]  good_reg,        good_next;
  logic [15:0] pixels_reg,      pixels_next;
  logic        frame_valid_reg, frame_valid_next;
  logic        locked_reg,      locked_next;
  logic [7:0]  err_cnt_reg,     err_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= HUNT;
      prev_reg        <= 2'd0;
      hold_reg        <= 4'd0;
      partial_reg     <= 16'h0000;
      good_reg        <= 4'd0;
      pixels_reg      <= 16'h0000;
      frame_valid_reg <= 1'b0;
      locked_reg      <= 1'b0;
      err_cnt_reg     <= 8'd0;
    end else begin
      state_reg       <= state_next;
      prev_reg        <= prev_next;
      hold_reg        <= hold_next;
      partial_reg     <= partial_next;
      good_reg        <= good_next;
      pixels_reg      <= pixels_next;
      frame_valid_reg <= frame_valid_next;
      locked_reg      <= locked_next;
      err_cnt_reg     <= err_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: scan sequencing and frame assembly
  // -------------------------------------------------------------------------
  logic        err_event;    // at most one error per sample
  logic        frame_done;   // row 3 captured in sequence
  logic        frame_ok;     // completed frame passes format/range checks
  logic        blank_abort;  // blank seen while collecting
  logic [15:0] frame_word;
  logic [4:0]  hold_inc;
  logic [1:0]  prev_inc;
  logic [3:0]  held_cols;

  // Completed frame = rows 0..2 already captured plus the current cols.
  assign frame_word = {cols_s, partial_reg[11:0]};
  assign frame_ok   = (frame_word[15:11] == 5'd0) &&
                      (frame_word[10:6] <= 5'd23) &&
                      (frame_word[5:0]  <= 6'd59);
  assign hold_inc   = {1'b0, hold_reg} + 5'd1;
  assign prev_inc   = prev_reg + 2'd1;
  assign held_cols  = partial_reg[{prev_reg, 2'b00} +: 4];

  always_comb begin
    state_next   = state_reg;
    prev_next    = prev_reg;
    hold_next    = hold_reg;
    partial_next = partial_reg;
    err_event    = 1'b0;
    frame_done   = 1'b0;
    blank_abort  = 1'b0;

    case (state_reg)
      HUNT: begin
        if (row_invalid) begin
          err_event = 1'b1;
        end else if (row_valid && (row_idx == 2'd0)) begin
          partial_next = {12'h000, cols_s};
          hold_next    = 4'd1;
          prev_next    = 2'd0;
          state_next   = COLLECT;
        end
      end

      COLLECT: begin
        if (row_blank) begin
          blank_abort  = 1'b1;
          partial_next = 16'h0000;
          hold_next    = 4'd0;
          prev_next    = 2'd0;
          state_next   = HUNT;
        end else if (row_invalid) begin
          err_event = 1'b1;
        end else if (row_idx == prev_reg) begin
          // Same row held: cols must stay put and hold must stay in budget.
          if ((cols_s != held_cols) || (hold_inc > HOLD_LIM)) begin
            err_event = 1'b1;
          end else begin
            hold_next = hold_inc[3:0];
          end
        end else if (row_idx == prev_inc) begin
          partial_next[{row_idx, 2'b00} +: 4] = cols_s;
          hold_next = 4'd1;
          prev_next = row_idx;
          if (row_idx == 2'd3) begin
            frame_done = 1'b1;
            if (!frame_ok) begin
              err_event = 1'b1;
            end
          end
        end else begin
          err_event = 1'b1;
        end
      end

      default: begin
        state_next = HUNT;
      end
    endcase

    // Error recovery: a valid row0 is reused as the start of a new frame,
    // anything else drops back to HUNT.
    if (err_event) begin
      if (row_valid && (row_idx == 2'd0)) begin
        partial_next = {12'h000, cols_s};
        hold_next    = 4'd1;
        prev_next    = 2'd0;
        state_next   = COLLECT;
      end else begin
        partial_next = 16'h0000;
        hold_next    = 4'd0;
        prev_next    = 2'd0;
        state_next   = HUNT;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: accepted frame, lock tracking, error counting
  // -------------------------------------------------------------------------
  always_comb begin
    pixels_next      = pixels_reg;
    frame_valid_next = 1'b0;
    good_next        = good_reg;
    locked_next      = locked_reg;
    err_cnt_next     = err_cnt_reg;

    if (err_event) begin
      err_cnt_next = (err_cnt_reg == 8'hFF) ? 8'hFF : err_cnt_reg + 8'd1;
      good_next    = 4'd0;
      locked_next  = 1'b0;
    end else if (blank_abort) begin
      good_next   = 4'd0;
      locked_next = 1'b0;
    end else if (frame_done) begin
      pixels_next      = frame_word;
      frame_valid_next = 1'b1;
      good_next        = (good_reg >= LOCK_LIM) ? good_reg : good_reg + 4'd1;
      locked_next      = (good_next >= LOCK_LIM);
    end
  end

  assign pixels      = pixels_reg;
  assign hours       = pixels_reg[10:6];
  assign minutes     = pixels_reg[5:0];
  assign frame_valid = frame_valid_reg;
  assign locked      = locked_reg;
  assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_matrix_scan_decoder
//
// Drives whole frames (optionally with one injected fault) into
// matrix_scan_decoder and predicts the outcome per frame from the frame
// value and the fault kind: accepted or not, error or not, lock progress.
// Directed steps follow the test plan, then random frames, then error
// counter saturation.
// ---------------------------------------------------------------------------
module tb_matrix_scan_decoder;

  localparam int HOLD_MAX = 4;
  localparam int LOCK     = 2;

  // fault kinds
  localparam int F_NONE    = 0;
  localparam int F_TIMEOUT = 1;
  localparam int F_GLITCH  = 2;
  localparam int F_SKIP    = 3;
  localparam int F_INVALID = 4;
  localparam int F_BLANK   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  scan_rows = 4'b0000;
  logic [3:0]  scan_cols = 4'b0000;
  logic [15:0] pixels;
  logic [4:0]  hours;
  logic [5:0]  minutes;
  logic        frame_valid;
  logic        locked;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  // reference model state (frame level)
  logic [15:0] m_pixels = 16'h0000;
  int          m_good   = 0;
  int          m_err    = 0;

  matrix_scan_decoder #(
    .HOLD_MAX   (HOLD_MAX),
    .LOCK_FRAMES(LOCK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_rows  (scan_rows),
    .scan_cols  (scan_cols),
    .pixels     (pixels),
    .hours      (hours),
    .minutes    (minutes),
    .frame_valid(frame_valid),
    .locked     (locked),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rowpat(input int r);
    logic [3:0] one;
    one = 4'h1 << r;
    return 4'hF ^ one;
  endfunction

  // one sample: apply, let the edge sample it, look 1 time unit later
  task automatic drive(input logic [3:0] r, input logic [3:0] c, input bit fv_exp);
    scan_rows = r;
    scan_cols = c;
    @(posedge clk);
    #1;
    check("frame_valid", {31'd0, frame_valid}, {31'd0, fv_exp});
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0] mp;
    mp = m_pixels;
    check({tag, ".pixels"},  {16'd0, pixels},  {16'd0, mp});
    check({tag, ".hours"},   {27'd0, hours},   {27'd0, mp[10:6]});
    check({tag, ".minutes"}, {26'd0, minutes}, {26'd0, mp[5:0]});
    check({tag, ".locked"},  {31'd0, locked},  (m_good == LOCK) ? 32'd1 : 32'd0);
    check({tag, ".err_cnt"}, {24'd0, err_cnt}, 32'(m_err));
  endtask

  // Sends one frame, rows 0..3; hold_n=0 picks a random hold per row.
  // A fault at row frow replaces/perturbs that row and ends the frame.
  task automatic send_frame(input string tag, input logic [15:0] val, input int hold_n,
                            input int fault, input int frow);
    bit          ok, reach3, acc, is_err, done;
    logic [3:0]  c, cc;
    int          hh, msk;
    ok     = (val[15:11] == 5'd0) && (val[10:6] <= 5'd23) && (val[5:0] <= 6'd59);
    reach3 = (fault == F_NONE) || (frow == 3 && (fault == F_TIMEOUT || fault == F_GLITCH));
    acc    = reach3 && ok;
    is_err = (fault >= F_TIMEOUT && fault <= F_INVALID) || (reach3 && !ok);
    done   = 1'b0;
    for (int r = 0; r < 4 && !done; r++) begin
      c  = val[4*r +: 4];
      hh = (hold_n == 0) ? int'($urandom_range(1, HOLD_MAX)) : hold_n;
      if (fault == F_TIMEOUT && r == frow) hh = HOLD_MAX + 1;
      if (fault == F_GLITCH && r == frow && hh < 2) hh = 2;
      if (r == frow && fault == F_SKIP) begin
        drive((r == 3) ? rowpat(1) : rowpat(3), c, 1'b0);
        done = 1'b1;
      end else if (r == frow && fault == F_INVALID) begin
        drive(4'b1100, c, 1'b0);
        done = 1'b1;
      end else if (r == frow && fault == F_BLANK) begin
        drive(4'b0000, c, 1'b0);
        done = 1'b1;
      end else begin
        for (int k = 0; k < hh && !done; k++) begin
          cc = c;
          if (fault == F_GLITCH && r == frow && k == 1) begin
            msk = $urandom_range(1, 15);
            cc  = c ^ 4'(msk);
          end
          drive(rowpat(r), cc, (r == 3 && k == 0) ? acc : 1'b0);
          if (fault == F_GLITCH && r == frow && k == 1) done = 1'b1;
          if (fault == F_TIMEOUT && r == frow && k == hh - 1) done = 1'b1;
        end
      end
    end
    // frame-level prediction
    if (acc) begin
      m_pixels = val;
      if (m_good < LOCK) m_good++;
    end
    if (is_err) begin
      if (m_err < 255) m_err++;
      m_good = 0;
    end
    if (fault == F_BLANK) m_good = 0;
    n_txn++;
    check_outputs(tag);
    $display("txn %0d %s val=%04h fault=%0d row=%0d acc=%0d err=%0d -> pixels=%04h locked=%0d err_cnt=%0d",
             n_txn, tag, val, fault, frow, acc, is_err, pixels, locked, err_cnt);
  endtask

  function automatic logic [15:0] mk_time(input int h, input int m);
    return {5'd0, 5'(h), 6'(m)};
  endfunction

  initial begin
    int kind, fr, h, m, up;
    logic [15:0] v;

    // ---- reset with random pins ----
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      scan_rows = 4'($urandom);
      scan_cols = 4'($urandom);
      @(posedge clk);
    end
    #1;
    check_outputs("reset");
    check("reset.frame_valid", {31'd0, frame_valid}, 32'd0);
    scan_rows = 4'b0000;
    scan_cols = 4'b0000;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset.err_cnt", {24'd0, err_cnt}, 32'd0);
    $display("txn 0 reset -> pixels=%04h err_cnt=%0d", pixels, err_cnt);

    // ---- good frames 13:42, lock after second ----
    send_frame("good_1342_a", 16'h036A, 1, F_NONE, 0);
    check("1342.hours",   {27'd0, hours},   32'd13);
    check("1342.minutes", {26'd0, minutes}, 32'd42);
    send_frame("good_1342_b", 16'h036A, 1, F_NONE, 0);
    check("1342.locked", {31'd0, locked}, 32'd1);

    // ---- sequence skip row0,row1,row3 then recovery ----
    send_frame("seq_skip", 16'h036A, 1, F_SKIP, 2);
    check("seq_skip.err_cnt", {24'd0, err_cnt}, 32'd1);
    send_frame("after_skip", mk_time(7, 5), 1, F_NONE, 0);

    // ---- hold limits ----
    send_frame("hold_max", mk_time(13, 42), HOLD_MAX, F_NONE, 0);
    send_frame("hold_over", mk_time(9, 9), 1, F_TIMEOUT, 1);
    send_frame("glitch", mk_time(9, 9), 3, F_GLITCH, 1);
    send_frame("refill", mk_time(13, 42), 2, F_NONE, 0);

    // ---- range / format rejection ----
    send_frame("min_60", 16'h003C, 1, F_NONE, 0);
    send_frame("hour_24", mk_time(24, 0), 1, F_NONE, 0);
    send_frame("format", 16'h136A, 1, F_NONE, 0);
    send_frame("edge_2359", mk_time(23, 59), 1, F_NONE, 0);

    // ---- blank mid-frame after lock ----
    send_frame("relock_a", mk_time(13, 42), 1, F_NONE, 0);
    check("relock.locked", {31'd0, locked}, 32'd1);
    send_frame("blank", mk_time(1, 1), 1, F_BLANK, 2);
    check("blank.locked", {31'd0, locked}, 32'd0);

    // ---- async reset mid-frame ----
    drive(rowpat(0), 4'hA, 1'b0);
    drive(rowpat(1), 4'h6, 1'b0);
    rst = 1'b1;
    #1;
    m_pixels = 16'h0000;
    m_good   = 0;
    m_err    = 0;
    check_outputs("async_rst");
    scan_rows = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("txn - async_rst -> pixels=%04h err_cnt=%0d", pixels, err_cnt);
    send_frame("after_rst", mk_time(13, 42), 1, F_NONE, 0);

    // ---- random frames ----
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 10);
      fr   = $urandom_range(1, 3);
      h    = $urandom_range(0, 23);
      m    = $urandom_range(0, 59);
      v    = mk_time(h, m);
      case (kind)
        0, 1, 2, 3: send_frame("rnd_good", v, 0, F_NONE, 0);
        4: begin
          if ($urandom_range(0, 1) == 1) v = mk_time($urandom_range(24, 31), m);
          else                           v = mk_time(h, $urandom_range(60, 63));
          send_frame("rnd_range", v, 0, F_NONE, 0);
        end
        5: begin
          up = $urandom_range(1, 31);
          v[15:11] = 5'(up);
          send_frame("rnd_format", v, 0, F_NONE, 0);
        end
        6: send_frame("rnd_timeout", v, 0, F_TIMEOUT, fr);
        7: send_frame("rnd_glitch", v, 0, F_GLITCH, fr);
        8: send_frame("rnd_skip", v, 0, F_SKIP, fr);
        9: send_frame("rnd_invalid", v, 0, F_INVALID, fr);
        default: send_frame("rnd_blank", v, 0, F_BLANK, fr);
      endcase
    end

    // ---- error counter saturation ----
    for (int i = 0; i < 300; i++) begin
      drive(4'b1100, 4'($urandom), 1'b0);
    end
    m_err  = 255;
    m_good = 0;
    check_outputs("saturate");
    $display("txn %0d saturate -> err_cnt=%0d", n_txn + 1, err_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
